// File: rtl/etapa_ex.sv
// Execute stage of the 5-stage MIPS pipeline: single-cycle ALU plus iterative
// 32-cycle multiply/divide into HI/LO, with an EX/MEM output register.
module etapa_ex (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [2:0]  alu_op,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  input  logic [4:0]  rd,
  input  logic [5:0]  funct,
  input  logic        reg_dst,
  output logic        stall,
  output logic        valid_out,
  output logic [31:0] result,
  output logic [31:0] store_data,
  output logic [4:0]  rd_out,
  output logic        reg_dst_out
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_R   = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [31:0] hi;
  logic [31:0] lo;

  // Iteration datapath; only meaningful while state is MUL or DIV
  logic [63:0] acc;
  logic [63:0] mcand;
  logic [31:0] mplier;
  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] dvsr;
  logic [31:0] dvd_raw;
  logic        neg_res;
  logic        neg_rem;
  logic        div_zero;

  logic        is_sgn;
  logic        issue_mul;
  logic        issue_div;
  logic [31:0] alu_res_p0;
  logic [63:0] acc_nxt;
  logic [63:0] prod_fix;
  logic [32:0] rem_sh;
  logic [32:0] diff;
  logic [31:0] rem_nxt;
  logic [31:0] quo_nxt;

  function automatic logic [31:0] mag(input logic [31:0] v, input logic sgn);
    mag = (sgn && v[31]) ? (32'd0 - v) : v;
  endfunction

  function automatic logic [31:0] alu_calc(input logic [2:0] op, input logic [5:0] fn,
                                           input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] h, input logic [31:0] l);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    alu_calc = 32'd0;
    case (op)
      OP_SUB: alu_calc = a - b;
      OP_AND: alu_calc = a & b;
      OP_OR:  alu_calc = a | b;
      OP_SLT: alu_calc = {31'd0, sa < sb};
      OP_R: begin
        case (fn)
          F_ADD:   alu_calc = a + b;
          F_SUB:   alu_calc = a - b;
          F_AND:   alu_calc = a & b;
          F_OR:    alu_calc = a | b;
          F_XOR:   alu_calc = a ^ b;
          F_NOR:   alu_calc = ~(a | b);
          F_SLT:   alu_calc = {31'd0, sa < sb};
          F_SLTU:  alu_calc = {31'd0, a < b};
          F_MFHI:  alu_calc = h;
          F_MFLO:  alu_calc = l;
          default: alu_calc = 32'd0;
        endcase
      end
      default: alu_calc = a + b;
    endcase
  endfunction

  assign stall      = (state != IDLE);
  assign is_sgn     = ~funct[0];
  assign issue_mul  = (state == IDLE) && valid_in && (alu_op == OP_R) &&
                      ((funct == F_MULT) || (funct == F_MULTU));
  assign issue_div  = (state == IDLE) && valid_in && (alu_op == OP_R) &&
                      ((funct == F_DIV) || (funct == F_DIVU));
  assign alu_res_p0 = alu_calc(alu_op, funct, data1, data2, hi, lo);

  // One shift-add step and one restoring-division step per cycle
  always_comb begin
    acc_nxt  = mplier[0] ? (acc + mcand) : acc;
    prod_fix = neg_res ? (64'd0 - acc_nxt) : acc_nxt;
    rem_sh   = {rem, quo[31]};
    diff     = rem_sh - {1'b0, dvsr};
    rem_nxt  = rem_sh[31:0];
    quo_nxt  = {quo[30:0], 1'b0};
    if (!diff[32]) begin
      rem_nxt = diff[31:0];
      quo_nxt = {quo[30:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (issue_mul) begin
      acc     <= 64'd0;
      mcand   <= {32'd0, mag(data1, is_sgn)};
      mplier  <= mag(data2, is_sgn);
      neg_res <= is_sgn && (data1[31] ^ data2[31]);
    end else if (state == MUL) begin
      acc    <= acc_nxt;
      mcand  <= {mcand[62:0], 1'b0};
      mplier <= {1'b0, mplier[31:1]};
    end
    if (issue_div) begin
      rem      <= 32'd0;
      quo      <= mag(data1, is_sgn);
      dvsr     <= mag(data2, is_sgn);
      dvd_raw  <= data1;
      div_zero <= (data2 == 32'd0);
      neg_res  <= is_sgn && (data1[31] ^ data2[31]);
      neg_rem  <= is_sgn && data1[31];
    end else if (state == DIV) begin
      rem <= rem_nxt;
      quo <= quo_nxt;
    end
  end

  // EX/MEM register, FSM and HI/LO
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 5'd0;
      hi          <= 32'd0;
      lo          <= 32'd0;
      valid_out   <= 1'b0;
      result      <= 32'd0;
      store_data  <= 32'd0;
      rd_out      <= 5'd0;
      reg_dst_out <= 1'b0;
    end else begin
      valid_out   <= 1'b0;
      result      <= 32'd0;
      store_data  <= 32'd0;
      rd_out      <= 5'd0;
      reg_dst_out <= 1'b0;
      case (state)
        IDLE: begin
          if (issue_mul) begin
            state <= MUL;
            cnt   <= 5'd0;
          end else if (issue_div) begin
            state <= DIV;
            cnt   <= 5'd0;
          end else if (valid_in) begin
            valid_out   <= 1'b1;
            result      <= alu_res_p0;
            store_data  <= data2;
            rd_out      <= rd;
            reg_dst_out <= reg_dst;
          end
        end
        MUL: begin
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            hi    <= prod_fix[63:32];
            lo    <= prod_fix[31:0];
            state <= IDLE;
          end
        end
        DIV: begin
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            state <= IDLE;
            if (div_zero) begin
              lo <= 32'hFFFF_FFFF;
              hi <= dvd_raw;
            end else begin
              lo <= neg_res ? (32'd0 - quo_nxt) : quo_nxt;
              hi <= neg_rem ? (32'd0 - rem_nxt) : rem_nxt;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_etapa_ex.sv
// Bench for etapa_ex: directed vector table, multicycle sequences and a
// random single-cycle stream, all checked through an output scoreboard.
module tb_etapa_ex;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic [2:0]  alu_op;
  logic [31:0] data1;
  logic [31:0] data2;
  logic [4:0]  rd;
  logic [5:0]  funct;
  logic        reg_dst;
  logic        stall;
  logic        valid_out;
  logic [31:0] result;
  logic [31:0] store_data;
  logic [4:0]  rd_out;
  logic        reg_dst_out;

  always #5 clk = ~clk;

  etapa_ex dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .alu_op(alu_op),
    .data1(data1), .data2(data2), .rd(rd), .funct(funct), .reg_dst(reg_dst),
    .stall(stall), .valid_out(valid_out), .result(result),
    .store_data(store_data), .rd_out(rd_out), .reg_dst_out(reg_dst_out)
  );

  typedef struct {
    logic [31:0] res;
    logic [31:0] sd;
    logic [4:0]  r;
    logic        rdst;
  } exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  exp_t        sb_q[$];
  vec_t        vt[18];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic [5:0]  fl[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [5:0] fn,
                                          input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    if (op == 3'b001) return a - b;
    if (op == 3'b011) return a & b;
    if (op == 3'b100) return a | b;
    if (op == 3'b101) return (sa < sb) ? 32'd1 : 32'd0;
    if (op != 3'b010) return a + b;
    case (fn)
      6'h20: return a + b;
      6'h22: return a - b;
      6'h24: return a & b;
      6'h25: return a | b;
      6'h26: return a ^ b;
      6'h27: return ~(a | b);
      6'h2A: return (sa < sb) ? 32'd1 : 32'd0;
      6'h2B: return (a < b) ? 32'd1 : 32'd0;
      6'h10: return m_hi;
      6'h12: return m_lo;
      default: return 32'd0;
    endcase
  endfunction

  // One single-cycle instruction (or bubble) through the stage
  task automatic step(input logic v, input logic [2:0] op, input logic [5:0] fn,
                      input logic [31:0] a, input logic [31:0] b, input logic [4:0] r,
                      input logic rdst, input logic [31:0] exp_res);
    exp_t e;
    valid_in = v; alu_op = op; funct = fn; data1 = a; data2 = b; rd = r; reg_dst = rdst;
    if (v) begin
      e.res = exp_res; e.sd = b; e.r = r; e.rdst = rdst;
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    chk("stall_single", stall, 1'b0);
    chk("valid_out", valid_out, sb_q.size() != 0);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      if (valid_out) begin
        chk("result", result, e.res);
        chk("store_data", store_data, e.sd);
        chk("rd_out", {rd_out, reg_dst_out}, {e.r, e.rdst});
      end
    end else begin
      chk("bubble_result", result, 32'd0);
      chk("bubble_fields", {store_data, rd_out, reg_dst_out}, 38'd0);
    end
  endtask

  // Issue a mult/div, hold an mfhi in ID/EX during the stall, update HI/LO model
  task automatic muldiv(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, p;
    longint unsigned ua, ub, up;
    int              cyc;
    logic            bub_ok;
    valid_in = 1'b1; alu_op = 3'b010; funct = fn; data1 = a; data2 = b; rd = 5'd3; reg_dst = 1'b1;
    @(posedge clk); #1;
    chk("issue_stall", stall, 1'b1);
    chk("issue_bubble", valid_out, 1'b0);
    funct = 6'h10; data1 = $urandom; data2 = $urandom;
    cyc = 0; bub_ok = 1'b1;
    while (stall && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (valid_out) bub_ok = 1'b0;
    end
    chk("stall_cycles", cyc, 32);
    chk("stall_bubbles", bub_ok, 1'b1);
    sa = {{32{a[31]}}, a}; sb = {{32{b[31]}}, b};
    ua = {32'd0, a};       ub = {32'd0, b};
    case (fn)
      6'h18: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
      6'h19: begin up = ua * ub; m_hi = up[63:32]; m_lo = up[31:0]; end
      6'h1A: begin
        if (b == 32'd0) begin m_lo = 32'hFFFF_FFFF; m_hi = a; end
        else begin p = sa / sb; m_lo = p[31:0]; p = sa % sb; m_hi = p[31:0]; end
      end
      default: begin
        if (b == 32'd0) begin m_lo = 32'hFFFF_FFFF; m_hi = a; end
        else begin up = ua / ub; m_lo = up[31:0]; up = ua % ub; m_hi = up[31:0]; end
      end
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0]  op;
    logic [5:0]  fn;
    logic [31:0] a, b;
    logic        v;

    vt[0]  = '{3'b010, 6'h20, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000};
    vt[1]  = '{3'b101, 6'h00, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    vt[2]  = '{3'b010, 6'h2B, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000};
    vt[3]  = '{3'b001, 6'h00, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE};
    vt[4]  = '{3'b000, 6'h00, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
    vt[5]  = '{3'b011, 6'h00, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
    vt[6]  = '{3'b100, 6'h00, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0};
    vt[7]  = '{3'b010, 6'h22, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
    vt[8]  = '{3'b010, 6'h26, 32'hFFFF_0000, 32'hF0F0_F0F0, 32'h0F0F_F0F0};
    vt[9]  = '{3'b010, 6'h27, 32'hF000_0000, 32'h0000_000F, 32'h0FFF_FFF0};
    vt[10] = '{3'b010, 6'h2A, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001};
    vt[11] = '{3'b010, 6'h2B, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0000};
    vt[12] = '{3'b010, 6'h24, 32'h1234_5678, 32'h0000_FFFF, 32'h0000_5678};
    vt[13] = '{3'b010, 6'h25, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678};
    vt[14] = '{3'b010, 6'h3F, 32'h0000_0001, 32'h0000_0002, 32'h0000_0000};
    vt[15] = '{3'b110, 6'h00, 32'h0000_0003, 32'h0000_0004, 32'h0000_0007};
    vt[16] = '{3'b111, 6'h00, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0001};
    vt[17] = '{3'b101, 6'h00, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000};
    fl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h10, 6'h12, 6'h00, 6'h3F};

    rst_n = 1'b0; valid_in = 1'b1; alu_op = 3'b000; funct = 6'h20;
    data1 = 32'h1111_1111; data2 = 32'h2222_2222; rd = 5'd7; reg_dst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_stall", stall, 1'b0);
    chk("reset_valid", valid_out, 1'b0);
    chk("reset_outputs", {result, store_data, rd_out, reg_dst_out}, 70'd0);
    rst_n = 1'b1;
    step(1'b1, 3'b010, 6'h10, 32'd0, 32'd0, 5'd1, 1'b0, 32'd0);

    for (int i = 0; i < 18; i++)
      step(1'b1, vt[i].op, vt[i].fn, vt[i].a, vt[i].b, 5'(i), i[0], vt[i].exp);
    step(1'b0, 3'b000, 6'h20, 32'h5, 32'h6, 5'd9, 1'b1, 32'd0);

    muldiv(6'h18, 32'hFFFF_FFFF, 32'h0000_0002);
    step(1'b1, 3'b010, 6'h10, 32'd0, 32'd0, 5'd8, 1'b1, 32'hFFFF_FFFF);
    step(1'b1, 3'b010, 6'h12, 32'd0, 32'd0, 5'd9, 1'b1, 32'hFFFF_FFFE);
    muldiv(6'h19, 32'hFFFF_FFFF, 32'h0000_0002);
    step(1'b1, 3'b010, 6'h10, 32'd0, 32'd0, 5'd8, 1'b1, 32'h0000_0001);
    step(1'b1, 3'b010, 6'h12, 32'd0, 32'd0, 5'd9, 1'b1, 32'hFFFF_FFFE);
    muldiv(6'h1A, 32'hFFFF_FFF9, 32'h0000_0002);
    step(1'b1, 3'b010, 6'h12, 32'd0, 32'd0, 5'd8, 1'b0, 32'hFFFF_FFFD);
    step(1'b1, 3'b010, 6'h10, 32'd0, 32'd0, 5'd9, 1'b0, 32'hFFFF_FFFF);
    muldiv(6'h1A, 32'h8000_0005, 32'h0000_0000);
    step(1'b1, 3'b010, 6'h10, 32'd0, 32'd0, 5'd8, 1'b0, 32'h8000_0005);
    // back-to-back: second issued in the first IDLE cycle after completion
    muldiv(6'h18, 32'h0000_1234, 32'h0001_0000);
    muldiv(6'h1B, 32'h0000_0007, 32'h0000_0000);
    step(1'b1, 3'b010, 6'h12, 32'd0, 32'd0, 5'd8, 1'b1, 32'hFFFF_FFFF);
    step(1'b1, 3'b010, 6'h10, 32'd0, 32'd0, 5'd9, 1'b1, 32'h0000_0007);

    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      b = (i == 2) ? 32'd0 : ((i % 2) ? $urandom : $urandom_range(1, 1000));
      muldiv(6'h18 + 6'($urandom_range(0, 3)), a, b);
      step(1'b1, 3'b010, 6'h10, 32'd0, 32'd0, 5'd8, 1'b1, m_hi);
      step(1'b1, 3'b010, 6'h12, 32'd0, 32'd0, 5'd9, 1'b1, m_lo);
    end

    // reset mid-multiply: product must never reach HI/LO
    valid_in = 1'b1; alu_op = 3'b010; funct = 6'h18; data1 = 32'd3; data2 = 32'd5;
    @(posedge clk); #1;
    funct = 6'h10;
    repeat (10) begin @(posedge clk); #1; end
    chk("mid_mult_stall", stall, 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_stall", stall, 1'b0);
    chk("abort_outputs", {valid_out, result, rd_out}, 38'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    step(1'b1, 3'b010, 6'h10, 32'd0, 32'd0, 5'd4, 1'b1, 32'd0);
    step(1'b1, 3'b010, 6'h12, 32'd0, 32'd0, 5'd5, 1'b0, 32'd0);
    step(1'b0, 3'b010, 6'h12, 32'd0, 32'd0, 5'd5, 1'b0, 32'd0);

    muldiv(6'h19, 32'h0001_0001, 32'h0001_0001);
    for (int i = 0; i < 200; i++) begin
      v  = ($urandom_range(0, 3) != 0);
      op = 3'($urandom_range(0, 7));
      fn = fl[$urandom_range(0, 11)];
      a  = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      step(v, op, fn, a, b, 5'($urandom), 1'($urandom), v ? ref_alu(op, fn, a, b) : 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
